// File: rtl/sd_sector_loader_if.sv
// Reader request/byte-stream and RAM write-port bundle for the SD sector loader.
interface sd_sector_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rstart;
    logic [31:0]       rsector;
    logic              rbusy;
    logic              rdone;
    logic              outen;
    logic [8:0]        outaddr;
    logic [7:0]        outbyte;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output rstart, rsector, mem_valid, mem_addr, mem_wdata,
        input  rbusy, rdone, outen, outaddr, outbyte, mem_ready
    );

    modport slave (
        input  rstart, rsector, mem_valid, mem_addr, mem_wdata,
        output rbusy, rdone, outen, outaddr, outbyte, mem_ready
    );
endinterface

// File: rtl/sd_sector_loader.sv
// Copies a run of SD sectors into RAM: bytes packed little-endian into words, buffered in a
// small FIFO, drained over valid/ready. Optional running checksum output: SDLOADER_CHECKSUM_EN.
module sd_sector_loader #(
    parameter int ADDR_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        first_sector,
    input  logic [15:0]        num_sectors,
    input  logic [ADDR_W-1:0]  ram_base,
    sd_sector_loader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [15:0]        sectors_done
`ifdef SDLOADER_CHECKSUM_EN
    ,
    output logic [31:0]        cksum
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_SEQ = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RECV, S_NEXT, S_DRAIN, S_ERR} state_t;

    state_t            state_q;
    logic              rstart_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [1:0]        err_code_q;
    logic [31:0]       rsector_q;
    logic [31:0]       first_q;
    logic [15:0]       num_q;
    logic [15:0]       sectors_done_q;
    logic [ADDR_W-1:0] base_q;
    logic [9:0]        byte_cnt_q;
    logic [9:0]        byte_cnt_d;
    logic [TMO_W-1:0]  tmo_q;

    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

    logic              fifo_empty, fifo_full, pop;
    logic              byte_ok, push_req, overflow, push;
    logic              tmo_hit, err_set, start_acc;
    logic [1:0]        err_val;
    logic [2:0]        lane_we;
    logic [31:0]       push_word;
    logic [ADDR_W-1:0] push_addr;
    logic [15:0]       sectors_inc;

    // Lanes 0..2 are held until lane 3 arrives; lane 3 goes straight into the pushed word.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_q <= '0;
            end else if (lane_we[gi]) begin
                lane_q <= bus.outbyte;
            end
        end
    end

    always_comb begin
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop         = !fifo_empty && bus.mem_ready;
        byte_ok     = (state_q == S_RECV) && bus.outen && ({1'b0, bus.outaddr} == byte_cnt_q);
        byte_cnt_d  = byte_cnt_q + {9'd0, byte_ok};
        push_req    = byte_ok && (bus.outaddr[1:0] == 2'd3);
        overflow    = push_req && fifo_full && !pop;
        push        = push_req && !overflow;
        push_word   = {bus.outbyte, g_lane[2].lane_q, g_lane[1].lane_q, g_lane[0].lane_q};
        push_addr   = base_q + ADDR_W'({sectors_done_q, 9'd0}) + ADDR_W'({bus.outaddr[8:2], 2'b00});
        tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        sectors_inc = sectors_done_q + 16'd1;
        start_acc   = start && ((state_q == S_IDLE) || (state_q == S_ERR));
        for (int i = 0; i < 3; i++) begin
            lane_we[i] = byte_ok && (bus.outaddr[1:0] == 2'(i));
        end

        err_set = 1'b0;
        err_val = 2'd0;
        if (state_q == S_ISSUE && tmo_hit) begin
            err_set = 1'b1;
            err_val = ERR_TMO;
        end else if (state_q == S_RECV) begin
            if (bus.outen && !byte_ok) begin
                err_set = 1'b1;
                err_val = ERR_SEQ;
            end else if (overflow) begin
                err_set = 1'b1;
                err_val = ERR_OVF;
            end else if (bus.rdone) begin
                if (byte_cnt_d != 10'd512) begin
                    err_set = 1'b1;
                    err_val = ERR_SEQ;
                end
            end else if (tmo_hit) begin
                err_set = 1'b1;
                err_val = ERR_TMO;
            end
        end

        wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
        if (err_set) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= push_word;
            fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rstart_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= 2'd0;
            rsector_q      <= '0;
            first_q        <= '0;
            num_q          <= '0;
            sectors_done_q <= '0;
            base_q         <= '0;
            byte_cnt_q     <= '0;
            tmo_q          <= '0;
        end else begin
            done_q <= 1'b0;
            if (err_set) begin
                state_q    <= S_ERR;
                rstart_q   <= 1'b0;
                busy_q     <= 1'b0;
                error_q    <= 1'b1;
                err_code_q <= err_val;
            end else begin
                case (state_q)
                    S_IDLE, S_ERR: begin
                        if (start) begin
                            first_q        <= first_sector;
                            num_q          <= num_sectors;
                            base_q         <= {ram_base[ADDR_W-1:2], 2'b00};
                            error_q        <= 1'b0;
                            err_code_q     <= 2'd0;
                            sectors_done_q <= '0;
                            byte_cnt_q     <= '0;
                            if (num_sectors == 16'd0) begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                busy_q    <= 1'b1;
                                rstart_q  <= 1'b1;
                                rsector_q <= first_sector;
                                tmo_q     <= '0;
                                state_q   <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (bus.rbusy) begin
                            rstart_q <= 1'b0;
                            state_q  <= S_RECV;
                        end
                    end
                    S_RECV: begin
                        if (byte_ok) begin
                            byte_cnt_q <= byte_cnt_d;
                        end
                        if (bus.rdone) begin
                            state_q <= S_NEXT;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_NEXT: begin
                        sectors_done_q <= sectors_inc;
                        byte_cnt_q     <= '0;
                        // Going through NEXT guarantees the reader sees rstart only after rdone has cleared.
                        if (sectors_inc == num_q) begin
                            state_q <= S_DRAIN;
                        end else begin
                            rstart_q  <= 1'b1;
                            rsector_q <= first_q + {16'd0, sectors_inc};
                            tmo_q     <= '0;
                            state_q   <= S_ISSUE;
                        end
                    end
                    S_DRAIN: begin
                        if (fifo_empty) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SDLOADER_CHECKSUM_EN
    logic [31:0] cksum_q;
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            cksum_q <= '0;
        end else if (pop) begin
            cksum_q <= cksum_q + bus.mem_wdata;
        end
    end
    assign cksum = cksum_q;
`endif

    // Head-of-FIFO fields are gated so the write port reads as zero while empty.
    assign bus.mem_valid = !fifo_empty;
    assign bus.mem_addr  = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.mem_wdata = fifo_empty ? '0 : fifo_data_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.rstart    = rstart_q;
    assign bus.rsector   = rsector_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign sectors_done  = sectors_done_q;
endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed + randomized bench: acts as SD reader and RAM, checks writes against a byte-array model.
module tb_sd_sector_loader;
    localparam int ADDR_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int TMO        = 1500;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       first_sector = '0;
    logic [15:0]       num_sectors = '0;
    logic [ADDR_W-1:0] ram_base = '0;
    logic              busy, done, error;
    logic [1:0]        err_code;
    logic [15:0]       sectors_done;
`ifdef SDLOADER_CHECKSUM_EN
    logic [31:0]       cksum;
`endif

    sd_sector_loader_if #(.ADDR_W(ADDR_W)) bus ();

    sd_sector_loader #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .first_sector(first_sector),
        .num_sectors(num_sectors), .ram_base(ram_base), .bus(bus),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .sectors_done(sectors_done)
`ifdef SDLOADER_CHECKSUM_EN
        , .cksum(cksum)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          ready_mode = 1;
    bit          stab_en = 1'b0;
    logic [7:0]  sbytes [4][512];
    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    bit          stall_prev = 1'b0;
    logic [31:0] prev_addr, prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM side: ready pattern per mode (1 always, 2 never, 3 random ~75%).
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            2:       bus.mem_ready = 1'b0;
            3:       bus.mem_ready = ($urandom_range(3, 0) != 0);
            default: bus.mem_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (stab_en && stall_prev)
            check("hold_stable", {31'd0, bus.mem_valid && bus.mem_addr == prev_addr &&
                                  bus.mem_wdata == prev_data}, 64'd1);
        if (bus.mem_valid && bus.mem_ready) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wdata);
            $display("write addr=0x%08h data=0x%08h", bus.mem_addr, bus.mem_wdata);
        end
        stall_prev = bus.mem_valid && !bus.mem_ready;
        prev_addr  = bus.mem_addr;
        prev_data  = bus.mem_wdata;
    end

    task automatic wait_rstart(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.rstart) ok = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [8:0] a, input logic [7:0] d, input int gap);
        bus.outen = 1'b1;
        bus.outaddr = a;
        bus.outbyte = d;
        tick();
        bus.outen = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_start(input logic [31:0] f, input logic [15:0] n, input logic [31:0] b);
        first_sector = f;
        num_sectors = n;
        ram_base = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack_request();
        tick();
        bus.rbusy = 1'b1;
        tick();
        bus.rbusy = 1'b0;
        check("rstart_drop", {63'd0, bus.rstart}, 64'd0);
    endtask

    task automatic serve_sector(input int s, input logic [31:0] exp_sec, input int gap_max, input bit poke);
        bit ok;
        wait_rstart(ok);
        check("rstart_seen", {63'd0, ok}, 64'd1);
        if (!ok) return;
        check("rsector", {32'd0, bus.rsector}, {32'd0, exp_sec});
        $display("request sector=0x%08h", bus.rsector);
        ack_request();
        for (int i = 0; i < 512; i++) begin
            if (poke && i == 100) pulse_start($urandom, 16'd5, $urandom);
            send_byte(9'(i), sbytes[s][i], $urandom_range(gap_max, 0));
        end
        bus.rdone = 1'b1;
        tick();
        bus.rdone = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] f, input int n, input logic [31:0] b,
                            input int gap_max, input bit poke);
        int d0;
        int bad;
        bit ok;
        logic [31:0] sum;
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
        sum = '0;
        for (int s = 0; s < n; s++) begin
            for (int w = 0; w < 128; w++) begin
                exp_addr.push_back((b & 32'hFFFF_FFFC) + 32'(s * 512) + 32'(w * 4));
                exp_data.push_back({sbytes[s][4*w+3], sbytes[s][4*w+2], sbytes[s][4*w+1], sbytes[s][4*w]});
                sum = sum + exp_data[$];
            end
        end
        d0 = done_cnt;
        pulse_start(f, 16'(n), b);
        for (int s = 0; s < n; s++) serve_sector(s, f + 32'(s), gap_max, poke && s == 0);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            if (done_cnt != d0) ok = 1'b1;
        end
        repeat (5) tick();
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("sectors_done", {48'd0, sectors_done}, 64'(n));
        check("busy_after", {63'd0, busy}, 64'd0);
        check("error_after", {63'd0, error}, 64'd0);
        check("write_count", 64'(got_addr.size()), 64'(exp_addr.size()));
        bad = -1;
        for (int i = 0; i < got_addr.size() && i < exp_addr.size() && bad < 0; i++)
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) bad = i;
        check("first_bad_write_idx", 64'(bad), 64'(-1));
`ifdef SDLOADER_CHECKSUM_EN
        check("cksum_model", {32'd0, cksum}, {32'd0, sum});
`endif
    endtask

    initial begin
        bit ok;
        int first_err;
        int viol;
        int k;

        bus.rbusy = 1'b0; bus.rdone = 1'b0; bus.outen = 1'b0; bus.outaddr = '0; bus.outbyte = '0;
        repeat (3) tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_err_code", {62'd0, err_code}, 64'd0);
        check("rst_sectors_done", {48'd0, sectors_done}, 64'd0);
        check("rst_rstart", {63'd0, bus.rstart}, 64'd0);
        check("rst_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
        check("rst_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
        rst = 1'b0;
        tick();

        // Two sectors, always-ready RAM, known first word.
        for (int s = 0; s < 4; s++) for (int i = 0; i < 512; i++) sbytes[s][i] = 8'($urandom);
        sbytes[0][0] = 8'h00; sbytes[0][1] = 8'h11; sbytes[0][2] = 8'h22; sbytes[0][3] = 8'h33;
        ready_mode = 1;
        stab_en = 1'b1;
        run_load(32'h800, 2, 32'h1000, 0, 1'b0);
        check("t1_first_data", {32'd0, got_data[0]}, 64'h3322_1100);
        check("t1_first_addr", {32'd0, got_addr[0]}, 64'h1000);
        check("t1_last_addr", {32'd0, got_addr[255]}, 64'h13FC);

        // Random bytes/base, random backpressure and gaps, a stray start mid-load.
        for (int s = 0; s < 4; s++) for (int i = 0; i < 512; i++) sbytes[s][i] = 8'($urandom);
        ready_mode = 3;
        run_load($urandom, 3, $urandom | 32'h3, 2, 1'b1);
        stab_en = 1'b0;
        ready_mode = 1;

        // Zero-length load.
        pulse_start(32'h55, 16'd0, 32'h8000);
        check("zero_done", {63'd0, done}, 64'd1);
        viol = 0;
        repeat (5) begin
            tick();
            if (bus.rstart || bus.mem_valid || busy || done) viol++;
        end
        check("zero_quiet", 64'(viol), 64'd0);

        // FIFO overflow with RAM stalled and a byte every 4 cycles.
        ready_mode = 2;
        tick();
        pulse_start(32'h10, 16'd1, 32'h2000);
        wait_rstart(ok);
        check("ovf_rstart_seen", {63'd0, ok}, 64'd1);
        ack_request();
        first_err = -1;
        for (int i = 0; i < 40 && first_err < 0; i++) begin
            send_byte(9'(i), 8'(i), 3);
            if (error) first_err = i;
        end
        $display("overflow seen at byte %0d", first_err);
        check("ovf_at_byte", 64'(first_err), 64'd19);
        check("ovf_err_code", {62'd0, err_code}, 64'd1);
        check("ovf_busy", {63'd0, busy}, 64'd0);
        check("ovf_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
        viol = 0;
        repeat (20) begin
            tick();
            if (bus.rstart || bus.mem_valid || !error) viol++;
        end
        check("ovf_quiet", 64'(viol), 64'd0);

        // Byte sequence error: reader jumps 4 -> 6.
        ready_mode = 1;
        tick();
        got_addr.delete(); got_data.delete();
        pulse_start(32'h20, 16'd1, 32'h3000);
        check("seq_error_cleared", {63'd0, error}, 64'd0);
        wait_rstart(ok);
        check("seq_rstart_seen", {63'd0, ok}, 64'd1);
        ack_request();
        for (int i = 0; i < 5; i++) send_byte(9'(i), 8'(i), 1);
        check("seq_no_err_yet", {63'd0, error}, 64'd0);
        send_byte(9'd6, 8'd6, 0);
        check("seq_error", {63'd0, error}, 64'd1);
        check("seq_err_code", {62'd0, err_code}, 64'd2);
        repeat (4) tick();
        check("seq_write_count", 64'(got_addr.size()), 64'd1);
        check("seq_write_addr", {32'd0, got_addr[0]}, 64'h3000);
        check("seq_write_data", {32'd0, got_data[0]}, 64'h0302_0100);

        // Timeout: request acknowledged but rdone never arrives.
        pulse_start(32'h30, 16'd1, 32'h4000);
        wait_rstart(ok);
        check("tmo_rstart_seen", {63'd0, ok}, 64'd1);
        k = 0;
        for (int i = 1; i <= TMO + 50 && k == 0; i++) begin
            @(negedge clk);
            if (i == 1) bus.rbusy = 1'b1;
            if (i == 2) bus.rbusy = 1'b0;
            if (error) k = i;
        end
        $display("timeout after %0d cycles", k);
        check("tmo_cycles", 64'(k), 64'(TMO));
        check("tmo_err_code", {62'd0, err_code}, 64'd3);
        check("tmo_busy", {63'd0, busy}, 64'd0);
        tick();
        for (int i = 0; i < 512; i++) sbytes[0][i] = 8'($urandom);
        run_load(32'h100, 1, 32'h4000, 1, 1'b0);

        // Reset in the middle of a sector with words waiting in the FIFO.
        ready_mode = 2;
        tick();
        pulse_start(32'h40, 16'd2, 32'h5000);
        wait_rstart(ok);
        check("rstmid_rstart_seen", {63'd0, ok}, 64'd1);
        ack_request();
        for (int i = 0; i < 10; i++) send_byte(9'(i), 8'(i), 0);
        check("rstmid_valid_before", {63'd0, bus.mem_valid}, 64'd1);
        rst = 1'b1;
        tick();
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        check("rstmid_rstart", {63'd0, bus.rstart}, 64'd0);
        check("rstmid_rsector", {32'd0, bus.rsector}, 64'd0);
        check("rstmid_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
        check("rstmid_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        rst = 1'b0;
        ready_mode = 1;
        viol = 0;
        repeat (20) begin
            tick();
            if (bus.mem_valid || bus.rstart || busy) viol++;
        end
        check("rstmid_quiet", 64'(viol), 64'd0);

`ifdef SDLOADER_CHECKSUM_EN
        for (int i = 0; i < 512; i++) sbytes[0][i] = 8'h01;
        run_load(32'h900, 1, 32'h6000, 0, 1'b0);
        check("cksum_ones", {32'd0, cksum}, 64'h8080_8080);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
